// File: rtl/ascii_key_fifo_decoder.sv
// ascii_key_fifo_decoder
//
// Decodes ASCII key bytes into small numeric codes and queues them in a
// power-of-two FIFO.
//   '1'..'9'         -> 1..9
//   'a'+k            -> 10+k   (k < N_LETTERS)
//   'A'+k            -> 10+k   (k < N_LETTERS, only when CASE_FOLD=1)
//   anything else    -> 0, counted in err_count (saturating at 255),
//                       queued as code 0 unless DROP_INVALID=1
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Producers hold data stable until it is accepted. The
// consumer sees out_code/out_valid held stable until out_ready takes them.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous clear of FIFO contents, pointers and err_count
//   in_data    ASCII byte          in_valid  byte present
//   in_ready   block can accept a byte this cycle
//   out_code   decoded code at FIFO head (0 when empty)
//   out_valid  out_code valid      out_ready consumer takes out_code
//   fill       current FIFO occupancy
//   err_count  accepted unmapped bytes, saturating

module ascii_key_fifo_decoder #(
  parameter int N_LETTERS    = 9,
  parameter int CASE_FOLD    = 0,
  parameter int DROP_INVALID = 0,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [7:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  // One past the last mapped letter, lowercase and uppercase.
  localparam logic [7:0]    LC_END   = 8'(8'h61 + N_LETTERS);
  localparam logic [7:0]    UC_END   = 8'(8'h41 + N_LETTERS);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill_q;
  logic [7:0]    err_q;
  // Cleared by reset, set on the first edge after reset; keeps in_ready
  // low while reset is held even though fill reads 0.
  logic          armed_q;

  logic [7:0]    dec_code;
  logic          dec_mapped;
  logic          accept;
  logic          push;
  logic          pop;

  // Byte decode, evaluated in the same cycle the byte is presented.
  always_comb begin
    dec_code   = 8'd0;
    dec_mapped = 1'b0;
    if (in_data >= 8'h31 && in_data <= 8'h39) begin
      dec_code   = in_data - 8'h30;
      dec_mapped = 1'b1;
    end else if (in_data >= 8'h61 && in_data < LC_END) begin
      dec_code   = in_data - 8'h61 + 8'd10;
      dec_mapped = 1'b1;
    end else if (CASE_FOLD != 0 && in_data >= 8'h41 && in_data < UC_END) begin
      dec_code   = in_data - 8'h41 + 8'd10;
      dec_mapped = 1'b1;
    end
  end

  // in_ready comes from state only, gated by flush so a byte offered in a
  // flush cycle is visibly refused rather than silently lost.
  assign in_ready  = armed_q & (fill_q != FILL_MAX) & ~flush;
  assign accept    = in_valid & in_ready;
  assign push      = accept & (dec_mapped | (DROP_INVALID == 0));
  assign pop       = (fill_q != '0) & out_ready;

  assign out_valid = (fill_q != '0);
  assign out_code  = out_valid ? mem[rd_ptr] : 8'd0;
  assign fill      = fill_q;
  assign err_count = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill_q  <= '0;
      err_q   <= 8'd0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill_q <= '0;
        err_q  <= 8'd0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fill_q <= fill_q + FW'(1);
          2'b01:   fill_q <= fill_q - FW'(1);
          default: fill_q <= fill_q;
        endcase
        if (accept && !dec_mapped && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while counted in fill.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec_code;
  end

endmodule

// File: tb/tb_ascii_key_fifo_decoder.sv
// Bench for ascii_key_fifo_decoder: three instances (defaults, case-folding
// with 26 letters, drop-invalid) share one stimulus stream and are checked
// every cycle against a queue-based model, plus literal scenario checks.

module tb_ascii_key_fifo_decoder;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b1;
  logic       flush     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data   = 8'h00;

  logic       in_ready_w  [NI];
  logic [7:0] out_code_w  [NI];
  logic       out_valid_w [NI];
  logic [2:0] fill_w      [NI];
  logic [7:0] err_w       [NI];

  ascii_key_fifo_decoder dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[0]), .out_code(out_code_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .fill(fill_w[0]),
    .err_count(err_w[0])
  );

  ascii_key_fifo_decoder #(.N_LETTERS(26), .CASE_FOLD(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[1]), .out_code(out_code_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .fill(fill_w[1]),
    .err_count(err_w[1])
  );

  ascii_key_fifo_decoder #(.DROP_INVALID(1)) dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w[2]), .out_code(out_code_w[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .fill(fill_w[2]),
    .err_count(err_w[2])
  );

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int nl [NI] = '{9, 26, 9};
  bit cf [NI] = '{1'b0, 1'b1, 1'b0};
  bit dr [NI] = '{1'b0, 1'b0, 1'b1};

  int mq     [NI][$];
  int merr   [NI];
  bit marmed [NI];

  function automatic int model_decode(input int i, input logic [7:0] b, output bit mapped);
    string digits = "123456789";
    string lower  = "abcdefghijklmnopqrstuvwxyz";
    string upper  = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    mapped = 1'b1;
    for (int k = 0; k < 9; k++)
      if (b == digits[k]) return k + 1;
    for (int k = 0; k < nl[i]; k++) begin
      if (b == lower[k]) return 10 + k;
      if (cf[i] && b == upper[k]) return 10 + k;
    end
    mapped = 1'b0;
    return 0;
  endfunction

  function automatic bit model_ready(input int i);
    return marmed[i] && (mq[i].size() < 4) && !flush;
  endfunction

  always @(posedge clk or posedge reset) begin
    bit rdy;
    bit mp;
    int c;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mq[i].delete();
        merr[i]   = 0;
        marmed[i] = 1'b0;
      end else begin
        rdy = model_ready(i);
        if (flush) begin
          mq[i].delete();
          merr[i] = 0;
        end else begin
          c = model_decode(i, in_data, mp);
          if (mq[i].size() != 0 && out_ready) void'(mq[i].pop_front());
          if (in_valid && rdy) begin
            if (mp || !dr[i]) mq[i].push_back(c);
            if (!mp && merr[i] < 255) merr[i]++;
          end
        end
        marmed[i] = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + output log ----------------
  logic [7:0] got  [NI][$];
  int         peak [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("dut%0d in_ready", i),  in_ready_w[i],  model_ready(i));
      chk($sformatf("dut%0d out_valid", i), out_valid_w[i], mq[i].size() != 0);
      chk($sformatf("dut%0d fill", i),      fill_w[i],      mq[i].size());
      chk($sformatf("dut%0d err_count", i), err_w[i],       merr[i]);
      if (mq[i].size() != 0)
        chk($sformatf("dut%0d out_code", i), out_code_w[i], mq[i][0]);
      else if (reset)
        chk($sformatf("dut%0d out_code in reset", i), out_code_w[i], 0);
      if (!reset && out_valid_w[i] === 1'b1 && out_ready) got[i].push_back(out_code_w[i]);
      if (int'(fill_w[i]) > peak[i]) peak[i] = int'(fill_w[i]);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; literal checks sample on
  // the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #0;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      got[i].delete();
      peak[i] = 0;
    end
  endtask

  task automatic chk_got(input int i, input string name, input int exp[$]);
    chk({name, " count"}, got[i].size(), exp.size());
    for (int k = 0; k < exp.size(); k++)
      if (k < got[i].size()) chk($sformatf("%s[%0d]", name, k), got[i][k], exp[k]);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // Reset held: everything idle, in_ready low.
    cyc(3);
    sample();
    chk("reset in_ready", in_ready_w[0], 0);
    chk("reset fill", fill_w[0], 0);
    chk("reset err_count", err_w[0], 0);
    chk("reset out_valid", out_valid_w[0], 0);
    chk("reset out_code", out_code_w[0], 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    sample();
    chk("post-reset in_ready", in_ready_w[0], 1);
    cyc(1);

    // '1','i','j','0' with a free-running consumer.
    out_ready = 1'b1;
    clear_logs();
    send("1"); send("i"); send("j"); send("0");
    cyc(4);
    sample();
    chk_got(0, "s1 dut0 codes", '{1, 18, 0, 0});
    chk("s1 dut0 err_count", err_w[0], 2);
    chk_got(1, "s1 dut1 codes", '{1, 18, 19, 0});
    chk_got(2, "s1 dut2 codes", '{1, 18});
    chk("s1 dut2 err_count", err_w[2], 2);
    cyc(1);

    // Case folding with all 26 letters.
    do_flush();
    clear_logs();
    send("Z"); send("z");
    cyc(3);
    sample();
    chk_got(1, "s2 dut1 codes", '{35, 35});
    chk("s2 dut1 err_count", err_w[1], 0);
    chk_got(0, "s2 dut0 codes", '{0, 0});
    cyc(1);

    // Dropping unmapped bytes.
    do_flush();
    clear_logs();
    send("*"); send("5");
    cyc(3);
    sample();
    chk_got(2, "s3 dut2 codes", '{5});
    chk("s3 dut2 err_count", err_w[2], 1);
    chk("s3 dut2 fill peak", peak[2], 1);
    cyc(1);

    // Fill to capacity with a stalled consumer, hold a fifth byte.
    do_flush();
    out_ready = 1'b0;
    clear_logs();
    send("1"); send("2"); send("3"); send("4");
    sample();
    chk("s4 full fill", fill_w[0], 4);
    chk("s4 full in_ready", in_ready_w[0], 0);
    cyc(1);
    in_data  = "5";
    in_valid = 1'b1;
    cyc(3);
    sample();
    chk("s4 held fill", fill_w[0], 4);
    cyc(1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    cyc(1);
    in_valid = 1'b0;
    sample();
    chk("s4 refill fill", fill_w[0], 4);
    cyc(1);
    out_ready = 1'b1;
    cyc(6);
    sample();
    chk_got(0, "s4 order", '{1, 2, 3, 4, 5});
    cyc(1);

    // Push and pop together: at fill=4 only the pop lands, at fill=3 both.
    out_ready = 1'b0;
    clear_logs();
    send("6"); send("7"); send("8"); send("9");
    sample();
    chk("s5 full fill", fill_w[0], 4);
    cyc(1);
    out_ready = 1'b1;
    in_data   = "a";
    in_valid  = 1'b1;
    cyc(1);
    sample();
    chk("s5 pop-only fill", fill_w[0], 3);
    cyc(1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sample();
    chk("s5 push+pop fill", fill_w[0], 3);
    cyc(1);
    out_ready = 1'b1;
    cyc(6);
    sample();
    chk_got(0, "s5 order", '{6, 7, 8, 9, 10});
    cyc(1);

    // 300 unmapped bytes saturate err_count; then flush beats a push.
    do_flush();
    in_data  = "*";
    in_valid = 1'b1;
    cyc(300);
    sample();
    for (int i = 0; i < NI; i++)
      chk($sformatf("s6 dut%0d err_count sat", i), err_w[i], 255);
    cyc(1);
    flush   = 1'b1;
    in_data = "1";
    sample();
    chk("s6 flush in_ready", in_ready_w[0], 0);
    cyc(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    sample();
    chk("s6 flushed fill", fill_w[0], 0);
    chk("s6 flushed err_count", err_w[0], 0);
    chk("s6 flushed out_valid", out_valid_w[0], 0);
    cyc(1);

    // Reset mid-stream discards contents immediately.
    out_ready = 1'b0;
    send("1"); send("2");
    sample();
    chk("s7 fill before reset", fill_w[0], 2);
    cyc(1);
    #1 reset = 1'b1;
    #1;
    chk("s7 async fill", fill_w[0], 0);
    chk("s7 async out_valid", out_valid_w[0], 0);
    chk("s7 async out_code", out_code_w[0], 0);
    chk("s7 async in_ready", in_ready_w[0], 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    sample();
    chk("s7 after reset out_valid", out_valid_w[0], 0);
    chk("s7 after reset in_ready", in_ready_w[0], 1);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
